// File: rtl/mux_rr_reg_if.sv
// Bundle of per-channel valid/ready inputs, the select input and the
// registered valid/ready output of the N-channel selector.
interface mux_rr_reg_if #(
    parameter int n  = 12,
    parameter int CH = 4
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH*n-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [SW-1:0]   sel;
    logic [n-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;

    // Environment side: drives producers, select and consumer ready.
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // Selector side.
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_rr_reg.sv
// Registered CH-channel selector with valid/ready on every port.
// MODE 0 = round-robin, 1 = fixed priority (lowest index), 2 = explicit sel.
// A one-entry output register gives 1-cycle latency and full throughput,
// since a new word may load in the same cycle the held word is consumed.
module mux_rr_reg #(
    parameter int n    = 12,
    parameter int CH   = 4,
    parameter int MODE = 0
) (
    input logic         clk,
    input logic         rst,
    mux_rr_reg_if.slave bus
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;

    logic [SW-1:0] last;
    logic [SW-1:0] grant_idx;
    logic          grant_valid;
    logic          can_load;
    logic [n-1:0]  grant_data;

    assign can_load = !bus.out_valid || bus.out_ready;

    // Pick the winning channel; nothing is granted while in reset or while the
    // output register is stalled, so in_ready stays low in those cycles.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (can_load && !rst) begin
            if (MODE == 0) begin
                // Channels above the pointer first, then wrap to the low ones.
                for (int j = 0; j < CH; j++) begin
                    if (!grant_valid && bus.in_valid[j] && (SW'(j) > last)) begin
                        grant_valid = 1'b1;
                        grant_idx   = SW'(j);
                    end
                end
                for (int j = 0; j < CH; j++) begin
                    if (!grant_valid && bus.in_valid[j] && (SW'(j) <= last)) begin
                        grant_valid = 1'b1;
                        grant_idx   = SW'(j);
                    end
                end
            end else if (MODE == 1) begin
                for (int j = 0; j < CH; j++) begin
                    if (!grant_valid && bus.in_valid[j]) begin
                        grant_valid = 1'b1;
                        grant_idx   = SW'(j);
                    end
                end
            end else begin
                // Select values with no matching channel give no grant.
                for (int j = 0; j < CH; j++) begin
                    if (bus.in_valid[j] && (bus.sel == SW'(j))) begin
                        grant_valid = 1'b1;
                        grant_idx   = SW'(j);
                    end
                end
            end
        end
    end

    // Decode the grant into the one-hot ready vector and the selected word.
    always_comb begin
        bus.in_ready = '0;
        grant_data   = '0;
        for (int j = 0; j < CH; j++) begin
            if (grant_valid && (grant_idx == SW'(j))) begin
                bus.in_ready[j] = 1'b1;
                grant_data      = bus.in_data[j*n +: n];
            end
        end
    end

    // Output register and round-robin pointer; both hold under back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            last          <= SW'(CH - 1);
        end else if (can_load) begin
            if (grant_valid) begin
                bus.out_data  <= grant_data;
                bus.out_ch    <= grant_idx;
                bus.out_valid <= 1'b1;
                if (MODE == 0) begin
                    last <= grant_idx;
                end
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: one instance per selection mode, all fed
// from the same stimulus, each checked only in its own phase.
module tb_mux_rr_reg;
    localparam int N  = 12;
    localparam int CH = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [SW-1:0]   sel;
    logic            out_ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [11:0] exp_data [6];
    logic [1:0]  exp_ch   [6];

    always #5 clk = ~clk;

    mux_rr_reg_if #(.n(N), .CH(CH)) bus_rr ();
    mux_rr_reg_if #(.n(N), .CH(CH)) bus_pri ();
    mux_rr_reg_if #(.n(N), .CH(CH)) bus_sel ();

    assign bus_rr.in_data    = in_data;
    assign bus_rr.in_valid   = in_valid;
    assign bus_rr.sel        = sel;
    assign bus_rr.out_ready  = out_ready;
    assign bus_pri.in_data   = in_data;
    assign bus_pri.in_valid  = in_valid;
    assign bus_pri.sel       = sel;
    assign bus_pri.out_ready = out_ready;
    assign bus_sel.in_data   = in_data;
    assign bus_sel.in_valid  = in_valid;
    assign bus_sel.sel       = sel;
    assign bus_sel.out_ready = out_ready;

    mux_rr_reg #(.n(N), .CH(CH), .MODE(0)) dut_rr  (.clk(clk), .rst(rst), .bus(bus_rr));
    mux_rr_reg #(.n(N), .CH(CH), .MODE(1)) dut_pri (.clk(clk), .rst(rst), .bus(bus_pri));
    mux_rr_reg #(.n(N), .CH(CH), .MODE(2)) dut_sel (.clk(clk), .rst(rst), .bus(bus_sel));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // ---------------- Reset with every channel requesting ----------------
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 48'hDDD_CCC_BBB_AAA;
        sel       = 2'd0;
        out_ready = 1'b1;
        #1;
        check("rst_rdy_rr",  32'(bus_rr.in_ready),  32'h0);
        check("rst_rdy_pri", 32'(bus_pri.in_ready), 32'h0);
        check("rst_rdy_sel", 32'(bus_sel.in_ready), 32'h0);
        tick();
        tick();
        check("rst_ovalid",  32'(bus_rr.out_valid), 32'h0);
        check("rst_odata",   32'(bus_rr.out_data),  32'h0);
        check("rst_och",     32'(bus_rr.out_ch),    32'h0);
        check("rst_ovalid_pri", 32'(bus_pri.out_valid), 32'h0);
        check("rst_ovalid_sel", 32'(bus_sel.out_valid), 32'h0);
        check("rst_rdy_rr2", 32'(bus_rr.in_ready),  32'h0);

        // ---------------- Round-robin rotation ----------------
        rst = 1'b0;
        #1;
        check("rr_first_rdy", 32'(bus_rr.in_ready), 32'h1);
        exp_data = '{12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD, 12'hAAA, 12'hBBB};
        exp_ch   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_ovalid", 32'(bus_rr.out_valid), 32'h1);
            check("rr_odata",  32'(bus_rr.out_data),  32'(exp_data[i]));
            check("rr_och",    32'(bus_rr.out_ch),    32'(exp_ch[i]));
            check("rr_rdy",    32'(bus_rr.in_ready),  32'(4'b0001 << ((i + 1) % 4)));
        end

        // ---------------- Skip idle channels and wrap ----------------
        rst      = 1'b1;
        in_valid = 4'b1010;
        tick();
        rst = 1'b0;
        #1;
        check("skip_ovalid0", 32'(bus_rr.out_valid), 32'h0);
        exp_data[0] = 12'hBBB; exp_data[1] = 12'hDDD; exp_data[2] = 12'hBBB;
        exp_ch[0]   = 2'd1;    exp_ch[1]   = 2'd3;    exp_ch[2]   = 2'd1;
        for (int i = 0; i < 3; i++) begin
            check("skip_rdy",   32'(bus_rr.in_ready), 32'(4'b0001 << exp_ch[i]));
            tick();
            check("skip_odata", 32'(bus_rr.out_data), 32'(exp_data[i]));
            check("skip_och",   32'(bus_rr.out_ch),   32'(exp_ch[i]));
        end

        // ---------------- Back-pressure on a held 0xBBB ----------------
        out_ready = 1'b0;
        #1;
        check("bp_rdy0", 32'(bus_rr.in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_odata",  32'(bus_rr.out_data),  32'hBBB);
            check("bp_ovalid", 32'(bus_rr.out_valid), 32'h1);
            check("bp_och",    32'(bus_rr.out_ch),    32'h1);
            check("bp_rdy",    32'(bus_rr.in_ready),  32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(bus_rr.in_ready), 32'h8);
        tick();
        check("bp_release_odata",  32'(bus_rr.out_data),  32'hDDD);
        check("bp_release_och",    32'(bus_rr.out_ch),    32'h3);
        check("bp_release_ovalid", 32'(bus_rr.out_valid), 32'h1);

        // ---------------- Fixed priority ----------------
        rst      = 1'b1;
        in_valid = 4'b0110;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("pri_rdy",   32'(bus_pri.in_ready), 32'h2);
            tick();
            check("pri_odata", 32'(bus_pri.out_data), 32'hBBB);
            check("pri_och",   32'(bus_pri.out_ch),   32'h1);
        end
        in_valid = 4'b0100;
        #1;
        check("pri_ch2_rdy", 32'(bus_pri.in_ready), 32'h4);
        tick();
        check("pri_ch2_odata", 32'(bus_pri.out_data), 32'hCCC);
        check("pri_ch2_och",   32'(bus_pri.out_ch),   32'h2);

        // ---------------- Explicit select ----------------
        rst      = 1'b1;
        sel      = 2'd2;
        in_valid = 4'b0100;
        tick();
        rst = 1'b0;
        #1;
        check("sel2_rdy", 32'(bus_sel.in_ready), 32'h4);
        tick();
        check("sel2_ovalid", 32'(bus_sel.out_valid), 32'h1);
        check("sel2_odata",  32'(bus_sel.out_data),  32'hCCC);
        check("sel2_och",    32'(bus_sel.out_ch),    32'h2);
        sel       = 2'd3;
        out_ready = 1'b0;
        #1;
        check("sel3_rdy_bp", 32'(bus_sel.in_ready), 32'h0);
        tick();
        check("sel3_hold_ovalid", 32'(bus_sel.out_valid), 32'h1);
        out_ready = 1'b1;
        #1;
        check("sel3_rdy", 32'(bus_sel.in_ready), 32'h0);
        tick();
        check("sel3_ovalid", 32'(bus_sel.out_valid), 32'h0);
        check("sel3_odata",  32'(bus_sel.out_data),  32'hCCC);
        check("sel3_och",    32'(bus_sel.out_ch),    32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised, registered N-channel selector. Generalises the team's combinational 2:1 data mux to CH channels with valid/ready handshakes on every port.
- Three selection modes: round-robin, fixed priority, or an explicit select input.
- Sits between multiple producers (ADC/sensor/datapath lanes) and a single downstream consumer.
- One-entry output register gives a 1-cycle latency and stable data under back-pressure.

Parameters:
- n, 12, data width in bits per channel.
- CH, 4, number of input channels; legal range 2..8.
- MODE, 0, selection mode:
  - 0 = round-robin.
  - 1 = fixed priority, lowest index wins.
  - 2 = explicit select via sel.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  CH*n  packed channel data; channel i occupies bits [i*n +: n].
- in_valid  input  CH  per-channel valid.
- in_ready  output  CH  per-channel ready. Combinational from state and inputs. At most one bit high per cycle.
- sel  input  max(1,$clog2(CH))  channel select; used only when MODE=2.
- out_data  output  n  registered selected word.
- out_ch  output  max(1,$clog2(CH))  index of the channel that produced out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_ch=0, rr pointer last=CH-1. Any buffered word is discarded, including when reset arrives mid-transfer. During reset, in_ready=0.
- Load condition: can_load = !out_valid || out_ready. The output register may accept a new word in the same cycle the old one is consumed, so full throughput is 1 word/cycle.
- Grant (combinational, evaluated only when can_load):
  - MODE 0: search channels last+1, last+2, … modulo CH; first with in_valid=1 wins.
  - MODE 1: lowest index with in_valid=1 wins.
  - MODE 2: channel sel wins only if in_valid[sel]=1; otherwise no grant. sel values >= CH mean no grant.
- Output signals: in_ready[g]=1 only for the granted channel g; all other in_ready bits are 0. in_ready is never asserted for a channel whose in_valid=0.
- Transfer on channel g: in_valid[g] && in_ready[g] at the edge. Then out_data<=in_data[g*n +: n], out_ch<=g, out_valid<=1. In MODE 0 only, last<=g.
- No grant while can_load: if out_ready=1, out_valid<=0; out_data and out_ch hold their last values.
- Back-pressure (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold; all in_ready=0; rr pointer holds.
- Round-robin fairness (MODE 0): with all channels continuously valid and out_ready=1, the grant order is 0,1,…,CH-1,0,… with no channel skipped or repeated. A channel that drops valid is skipped without losing a cycle.
- Wrap-around: the search starting from last=CH-1 begins at channel 0.
- Latency: exactly 1 clk from the input transfer to out_valid/out_data visible.
- Width rules: n and CH are free within range. in_data is not sign-extended or otherwise modified. out_ch is zero when CH=2 and channel 0 is granted.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1111 → out_valid=0, out_data=0, out_ch=0, in_ready=0000 during reset. After release, the first grant is ch0.
- RR rotation (n=12, CH=4, MODE 0): in_data={0xDDD,0xCCC,0xBBB,0xAAA}, in_valid=1111, out_ready=1 for 6 cycles → out_data sequence 0xAAA,0xBBB,0xCCC,0xDDD,0xAAA,0xBBB; out_ch 0,1,2,3,0,1.
- Skip and wrap (MODE 0): in_valid=1010, last=3 → grants ch1 then ch3 then ch1. in_ready is never high on ch0 or ch2.
- Back-pressure: out_valid=1 with out_data=0xBBB; hold out_ready=0 for 3 cycles → out_data stays 0xBBB and in_ready=0000. Raise out_ready → the next word loads the same cycle the held word is consumed.
- Fixed priority (MODE 1): in_valid=0110 → ch1 is granted every cycle and ch2 starves. Then in_valid=0100 → ch2 is granted.
- Explicit select (MODE 2): sel=2 with in_valid=0100 → 0xCCC out after 1 cycle. Then sel=3 with in_valid=0100 → no grant, and out_valid drops to 0 once the held word is consumed.
